// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ==========================================================================
// fft_bitrev_reorder : bit-reversed FFT bins -> natural-order framed stream
// Rev 1.0
// ==========================================================================
module fft_bitrev_reorder #(
  parameter int N     = 128,
  parameter int LOG2N = 7,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic          overflow
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  logic [DW-1:0]    mem_q [2*N];

  state_t           state_q, state_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             drop_q, drop_d;
  logic [1:0]       full_q, full_d;
  logic             rd_bank_q, rd_bank_d;
  logic             overflow_q, overflow_d;
  logic             iss_bank_q, iss_bank_d;
  logic [LOG2N-1:0] iss_addr_q, iss_addr_d;
  logic             rv_q, rv_d;
  logic             rsop_q, rsop_d;
  logic             reop_q, reop_d;
  logic [DW-1:0]    rdata_q;
  logic             skid_v_q, skid_v_d;
  logic [DW-1:0]    skid_data_q, skid_data_d;
  logic             skid_sop_q, skid_sop_d;
  logic             skid_eop_q, skid_eop_d;

  logic             w_pop, w_head_eop, w_release;
  logic             w_wr_first, w_wr_last, w_drop, w_we, w_re;
  logic [1:0]       w_rel_mask, w_eff_full, w_rem;

  // Output head is the skid entry when present (older), otherwise the RAM read register.
  assign out_valid  = skid_v_q | rv_q;
  assign out_data   = skid_v_q ? skid_data_q : (rv_q ? rdata_q : '0);
  assign out_sop    = skid_v_q ? skid_sop_q  : (rv_q & rsop_q);
  assign out_eop    = skid_v_q ? skid_eop_q  : (rv_q & reop_q);
  assign overflow   = overflow_q;

  assign w_pop      = out_valid & out_ready;
  assign w_head_eop = skid_v_q ? skid_eop_q : reop_q;
  assign w_release  = (state_q == S_STREAM) & w_pop & w_head_eop;
  assign w_rel_mask = w_release ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign w_eff_full = full_q & ~w_rel_mask;

  assign w_wr_first = (wr_cnt_q == '0);
  assign w_wr_last  = &wr_cnt_q;
  assign w_drop     = w_wr_first ? w_eff_full[wr_bank_q] : drop_q;
  assign w_we       = in_valid & ~w_drop;

  // Entries left after this cycle's pop; a new read fits only if at most one remains.
  assign w_rem      = {1'b0, skid_v_q} + {1'b0, rv_q} - {1'b0, w_pop};
  assign w_re       = (w_rem != 2'd2) & full_q[iss_bank_q];

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    full_d     = full_q & ~w_rel_mask;
    if (in_valid) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (w_wr_first) begin
        drop_d = w_eff_full[wr_bank_q];
        if (w_eff_full[wr_bank_q]) overflow_d = 1'b1;
      end
      if (w_we && w_wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (w_release) begin
          rd_bank_d = ~rd_bank_q;
          state_d   = full_q[~rd_bank_q] ? S_STREAM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read issue may run ahead into the next full bank so frames stream without a bubble.
  always_comb begin
    iss_addr_d  = iss_addr_q;
    iss_bank_d  = iss_bank_q;
    rsop_d      = rsop_q;
    reop_d      = reop_q;
    rv_d        = w_re | (w_rem == 2'd2);
    skid_v_d    = (w_rem != 2'd0);
    skid_data_d = skid_data_q;
    skid_sop_d  = skid_sop_q;
    skid_eop_d  = skid_eop_q;
    if (w_re) begin
      iss_addr_d = iss_addr_q + 1'b1;
      if (&iss_addr_q) iss_bank_d = ~iss_bank_q;
      rsop_d = (iss_addr_q == '0);
      reop_d = &iss_addr_q;
    end
    if ((w_rem != 2'd0) && !(skid_v_q && !w_pop)) begin
      skid_data_d = rdata_q;
      skid_sop_d  = rsop_q;
      skid_eop_d  = reop_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      drop_q     <= 1'b0;
      full_q     <= 2'b00;
      rd_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
      iss_bank_q <= 1'b0;
      iss_addr_q <= '0;
      rv_q       <= 1'b0;
      rsop_q     <= 1'b0;
      reop_q     <= 1'b0;
      skid_v_q   <= 1'b0;
      skid_sop_q <= 1'b0;
      skid_eop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      drop_q     <= drop_d;
      full_q     <= full_d;
      rd_bank_q  <= rd_bank_d;
      overflow_q <= overflow_d;
      iss_bank_q <= iss_bank_d;
      iss_addr_q <= iss_addr_d;
      rv_q       <= rv_d;
      rsop_q     <= rsop_d;
      reop_q     <= reop_d;
      skid_v_q   <= skid_v_d;
      skid_sop_q <= skid_sop_d;
      skid_eop_q <= skid_eop_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    if (w_we) mem_q[{wr_bank_q, bitrev(wr_cnt_q)}] <= in_data;
    if (w_re) rdata_q <= mem_q[{iss_bank_q, iss_addr_q}];
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ==========================================================================
// tb_fft_bitrev_reorder : scoreboard bench for the bit-reversal reorder buffer
// Rev 1.0
// ==========================================================================
module tb_fft_bitrev_reorder;
  localparam int N     = 128;
  localparam int LOG2N = 7;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          overflow;

  fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW+1:0] exp_q[$];   // {sop, eop, data}

  logic rand_ready = 1'b0;
  logic lat_arm    = 1'b0;
  int   first_valid_cyc = -1;
  logic win_en     = 1'b0;
  int   hs_count   = 0;
  int   hs_first   = 0;
  int   hs_last    = 0;

  function automatic logic [LOG2N-1:0] brev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Natural bin j of frame f: re = f*256+j, im = j (frame 0 gives {j, j}).
  function automatic logic [DW-1:0] val(input int f, input int j);
    return {16'(f * 256 + j), 16'(j)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) if (rand_ready) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_out;

  always @(negedge clk) begin
    logic [DW+1:0] cur;
    logic [DW+1:0] e;
    cur = {out_sop, out_eop, out_data};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_hold", 64'(cur), 64'(prev_out));
      end
      if (!out_valid) check("idle_sop_eop", 64'({out_sop, out_eop}), 64'(0));
      if (out_valid && lat_arm) begin
        first_valid_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected no output (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", 64'(cur), 64'(e));
        end
        if (win_en) begin
          if (hs_count == 0) hs_first = cyc;
          hs_last = cyc;
          hs_count++;
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_out   = cur;
    end
  end

  task automatic send_frame(input int f, input bit push, input bit now);
    if (push)
      for (int j = 0; j < N; j++) exp_q.push_back({(j == 0), (j == N-1), val(f, j)});
    for (int k = 0; k < N; k++) begin
      if (!(now && k == 0)) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = val(f, int'(brev(LOG2N'(k))));
      last_cyc = cyc;
    end
  endtask

  task automatic stop_in();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_room(input int budget);
    int n = 0;
    while (exp_q.size() > N && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("t3_room", 64'(exp_q.size() <= N), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_sop_eop", 64'({out_sop, out_eop}), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));

    // T1: single frame, latency W+2
    @(posedge clk); #1;
    out_ready = 1'b1; lat_arm = 1'b1;
    send_frame(0, 1'b1, 1'b0);
    stop_in();
    wait_drain("t1_drain", 400);
    check("t1_latency", 64'(first_valid_cyc), 64'(last_cyc + 2));

    // T2: four back-to-back frames, gapless output
    hs_count = 0; win_en = 1'b1;
    for (int f = 1; f <= 4; f++) send_frame(f, 1'b1, 1'b0);
    stop_in();
    wait_drain("t2_drain", 800);
    win_en = 1'b0;
    check("t2_count", 64'(hs_count), 64'(512));
    check("t2_no_gap", 64'(hs_last - hs_first + 1), 64'(512));
    check("t2_overflow", 64'(overflow), 64'(0));

    // T3: random backpressure
    rand_ready = 1'b1;
    for (int f = 5; f <= 7; f++) begin
      wait_room(3000);
      send_frame(f, 1'b1, 1'b0);
      stop_in();
    end
    wait_drain("t3_drain", 3000);
    @(negedge clk);
    rand_ready = 1'b0; out_ready = 1'b1;
    check("t3_overflow", 64'(overflow), 64'(0));

    // T5: bank release in the same cycle as a new frame's first sample
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_frame(8, 1'b1, 1'b0);
    send_frame(9, 1'b1, 1'b0);
    stop_in();
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_eop && out_ready) found = 1'b1;
    end
    check("t5_eop_seen", 64'(found), 64'(1));
    send_frame(10, 1'b1, 1'b1);
    stop_in();
    wait_drain("t5_drain", 800);
    check("t5_overflow", 64'(overflow), 64'(0));

    // T4: both banks full, third frame dropped
    out_ready = 1'b0;
    send_frame(11, 1'b1, 1'b0);
    send_frame(12, 1'b1, 1'b0);
    check("t4_overflow_pre", 64'(overflow), 64'(0));
    send_frame(13, 1'b0, 1'b0);
    stop_in();
    @(negedge clk);
    check("t4_overflow", 64'(overflow), 64'(1));
    check("t4_stall_valid", 64'(out_valid), 64'(1));
    check("t4_stall_bin0", 64'({out_sop, out_data}), 64'({1'b1, val(11, 0)}));
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("t4_drain", 800);
    repeat (20) @(posedge clk);
    #1;
    check("t4_overflow_sticky", 64'(overflow), 64'(1));

    // T6: reset during input sample 60 and output bin 40
    out_ready = 1'b0;
    send_frame(14, 1'b1, 1'b0);
    for (int k = 0; k <= 60; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = val(15, int'(brev(LOG2N'(k))));
      if (k == 20) out_ready = 1'b1;
      if (k == 60) begin
        rst = 1'b1;
        check("t6_bin40", 64'(out_data), 64'(val(14, 40)));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    exp_q.delete();
    check("t6_rst_valid", 64'(out_valid), 64'(0));
    check("t6_rst_data", 64'(out_data), 64'(0));
    check("t6_rst_sop_eop", 64'({out_sop, out_eop}), 64'(0));
    check("t6_rst_overflow", 64'(overflow), 64'(0));
    send_frame(16, 1'b1, 1'b0);
    stop_in();
    wait_drain("t6_drain", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
